tx_dispatch: RTL and testbench
==============================

TX_DISPATCH -- requirements
Module: tx_dispatch

Interface
REQ-001 Parameter SIZE, default 8: item width in bits.
REQ-002 Parameter NPORTS, default 5: number of output ports (0=N, 1=S, 2=E, 3=W, 4=L at default).
REQ-003 Parameter BITS_DIR, default 3: routing-table data width; SHALL satisfy 2^BITS_DIR >= NPORTS.
REQ-004 Parameter PKT_LEN, default 1: items per packet (>=1); route is looked up on the head item only.
REQ-005 Parameter STALL_MAX, default 255: stall counter saturation value (>=1).
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 empty  in  1  source FIFO empty flag.
REQ-009 read  out  1  combinational FIFO pop strobe; one item consumed per cycle asserted.
REQ-010 item_in  in  SIZE  FIFO head item.
REQ-011 table_addr  out  SIZE  combinational, equal to item_in at all times.
REQ-012 table_data  in  BITS_DIR  combinational routing-table answer for table_addr.
REQ-013 item_out  out  SIZE  registered copy of the last transferred item.
REQ-014 port_ena  out  NPORTS  registered one-hot (or zero) transfer strobe per port.
REQ-015 port_busy  in  NPORTS  per-port busy; sampled in the cycle read would assert.
REQ-016 stall  out  1  registered; high while stall counter equals STALL_MAX.
REQ-017 route_err  out  1  registered sticky flag; set on an out-of-range direction.

Function
REQ-018 FSM states: HEAD (awaiting packet head), BODY (forwarding remaining PKT_LEN-1 items on locked route).
REQ-019 In HEAD, target dir = table_data; in BODY, target dir = dir latched at head transfer.
REQ-020 Transfer condition: !empty and dir < NPORTS and !port_busy[dir]; read SHALL be 1 exactly when transfer condition holds or a discard occurs (REQ-024).
REQ-021 On transfer, next edge: item_out <= item_in, port_ena <= one-hot(dir); otherwise port_ena <= 0 and item_out holds; latency item_in to port_ena = 1 cycle.
REQ-022 Back-to-back transfers allowed every cycle; port_ena may stay high for consecutive cycles.
REQ-023 Item counter counts transfers within a packet; HEAD->BODY on head transfer when PKT_LEN>1; BODY->HEAD on the PKT_LEN-th transfer; PKT_LEN=1 stays in HEAD permanently.
REQ-024 In HEAD with !empty and table_data >= NPORTS: read=1 (item discarded), no port_ena, route_err <= 1, packet discarded item-by-item via BODY with invalid locked dir, counter advancing as for transfers.
REQ-025 route_err SHALL clear only on reset.
REQ-026 port_busy of non-target ports SHALL be ignored; busy on target blocks with no read, state and counter held.
REQ-027 Empty in BODY: hold state, lock and counter; no read; stall counter not incremented.
REQ-028 Stall counter increments each cycle with !empty and target busy, saturates at STALL_MAX, clears to 0 on any transfer or discard.
REQ-029 stall <= (next counter value == STALL_MAX).
REQ-030 Counter widths SHALL be clog2-sized from PKT_LEN and STALL_MAX; no wrap beyond bounds.

Reset
REQ-031 rst_n low asynchronously forces: state HEAD, item counter 0, locked dir 0, stall counter 0, item_out 0, port_ena 0, stall 0, route_err 0.
REQ-032 While rst_n low, read SHALL be 0 regardless of inputs.
REQ-033 Reset mid-packet abandons the lock; first item after release is treated as a head.

Verification
REQ-034 PKT_LEN=1, items 0x11->dir 2, 0x22->dir 4 back-to-back, ports idle -> read high 2 cycles; port_ena 00100 then 10000; item_out 0x11 then 0x22.
REQ-035 PKT_LEN=4, head table_data=1, table_data changes to 3 on body items -> all 4 items on port_ena bit 1; fifth item routed by table_data.
REQ-036 Target port busy 3 cycles mid-packet, other ports idle -> read low 3 cycles, no port_ena, transfer resumes on 4th cycle with item intact.
REQ-037 STALL_MAX=4, target busy 6 cycles -> stall rises after 4th busy cycle, stays high, drops the cycle after the transfer.
REQ-038 NPORTS=5, table_data=6 on head, PKT_LEN=2 -> 2 items read and discarded, no port_ena, route_err high until rst_n.
REQ-039 rst_n pulsed low in BODY after 2 of 4 items -> outputs at reset values immediately; next item routed via table_data.

Source files
------------

// File: rtl/tx_dispatch_if.sv
// Dispatcher bus bundle: source FIFO head, routing-table lookup, per-port strobes and status.
// The master modport is the dispatcher; the slave modport is the FIFO/table/port environment.
interface tx_dispatch_if #(
  parameter int SIZE     = 8,
  parameter int NPORTS   = 5,
  parameter int BITS_DIR = 3
);
  logic                empty;
  logic                read;
  logic [SIZE-1:0]     item_in;
  logic [SIZE-1:0]     table_addr;
  logic [BITS_DIR-1:0] table_data;
  logic [SIZE-1:0]     item_out;
  logic [NPORTS-1:0]   port_ena;
  logic [NPORTS-1:0]   port_busy;
  logic                stall;
  logic                route_err;
  logic                state_dbg;

  // Handshake: one item leaves the FIFO on every rising edge where read is high;
  // read is high only when empty is low and the item is either transferred or discarded.
  modport master (
    input  empty, item_in, table_data, port_busy,
    output read, table_addr, item_out, port_ena, stall, route_err, state_dbg
  );

  modport slave (
    output empty, item_in, table_data, port_busy,
    input  read, table_addr, item_out, port_ena, stall, route_err, state_dbg
  );
endinterface

// File: rtl/tx_dispatch.sv
// Packet dispatcher: routes the head item through a lookup table, locks the route for
// the rest of the packet, and forwards items one per cycle to the selected output port.
module tx_dispatch #(
  parameter int SIZE      = 8,
  parameter int NPORTS    = 5,
  parameter int BITS_DIR  = 3,
  parameter int PKT_LEN   = 1,
  parameter int STALL_MAX = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  tx_dispatch_if.master bus
);
  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int STL_W = $clog2(STALL_MAX + 1);

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [BITS_DIR-1:0] lock_dir, lock_next;
  logic [STL_W-1:0]    stall_cnt, stall_next;
  logic [BITS_DIR-1:0] dir;
  logic [NPORTS-1:0]   dir_onehot;
  logic                dir_ok;
  logic                tgt_busy;
  logic                xfer;
  logic                discard;
  logic                advance;
  logic [SIZE-1:0]     item_q;
  logic [NPORTS-1:0]   ena_q;
  logic                stall_q;
  logic                err_q;

  // An out-of-range direction decodes to an all-zero one-hot, which doubles as the range check.
  always_comb begin
    dir        = (state == HEAD) ? bus.table_data : lock_dir;
    dir_onehot = '0;
    for (int p = 0; p < NPORTS; p++) begin
      dir_onehot[p] = (dir == BITS_DIR'(p));
    end
    dir_ok   = |dir_onehot;
    tgt_busy = |(dir_onehot & bus.port_busy);
    xfer     = !bus.empty && dir_ok && !tgt_busy;
    discard  = !bus.empty && !dir_ok;
    advance  = xfer || discard;
  end

  assign bus.read       = rst_n && advance;
  assign bus.table_addr = bus.item_in;
  assign bus.item_out   = item_q;
  assign bus.port_ena   = ena_q;
  assign bus.stall      = stall_q;
  assign bus.route_err  = err_q;
  assign bus.state_dbg  = (state == BODY);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lock_next  = lock_dir;
    case (state)
      HEAD: begin
        if (advance) begin
          lock_next = bus.table_data;
          if (PKT_LEN > 1) begin
            state_next = BODY;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      BODY: begin
        if (advance) begin
          if (cnt == CNT_W'(PKT_LEN - 1)) begin
            state_next = HEAD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = HEAD;
        cnt_next   = '0;
      end
    endcase
  end

  // Stall count only moves while an item is waiting on a busy target; empty cycles hold it.
  always_comb begin
    stall_next = stall_cnt;
    if (advance) begin
      stall_next = '0;
    end else if (!bus.empty && tgt_busy && (stall_cnt != STL_W'(STALL_MAX))) begin
      stall_next = stall_cnt + STL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HEAD;
      cnt       <= '0;
      lock_dir  <= '0;
      stall_cnt <= '0;
      item_q    <= '0;
      ena_q     <= '0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lock_dir  <= lock_next;
      stall_cnt <= stall_next;
      stall_q   <= (stall_next == STL_W'(STALL_MAX));
      ena_q     <= xfer ? dir_onehot : '0;
      if (xfer) begin
        item_q <= bus.item_in;
      end
      if ((state == HEAD) && discard) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tx_dispatch.sv
// Directed and randomized checks of tx_dispatch (PKT_LEN=4, STALL_MAX=4) against a
// packet-position reference model.
module tb_tx_dispatch;
  localparam int SIZE = 8;
  localparam int NP   = 5;
  localparam int BD   = 3;
  localparam int PL   = 4;
  localparam int SM   = 4;

  logic clk;
  logic rst_n;

  tx_dispatch_if #(.SIZE(SIZE), .NPORTS(NP), .BITS_DIR(BD)) bus ();

  tx_dispatch #(
    .SIZE(SIZE), .NPORTS(NP), .BITS_DIR(BD), .PKT_LEN(PL), .STALL_MAX(SM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: position within packet, route of current packet, stall count.
  int              m_pos;
  int              m_route;
  int              m_scnt;
  logic [SIZE-1:0] m_item;
  logic [NP-1:0]   m_ena;
  logic            m_stall;
  logic            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_pos = 0; m_route = 0; m_scnt = 0;
    m_item = '0; m_ena = '0; m_stall = 1'b0; m_err = 1'b0;
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, "_item_out"},  32'(bus.item_out),  32'(m_item));
    chk({pfx, "_port_ena"},  32'(bus.port_ena),  32'(m_ena));
    chk({pfx, "_stall"},     32'(bus.stall),     32'(m_stall));
    chk({pfx, "_route_err"}, 32'(bus.route_err), 32'(m_err));
    chk({pfx, "_in_body"},   32'(bus.state_dbg), 32'(m_pos != 0));
  endtask

  // One clock cycle: drive, check comb outputs, advance model, check registered outputs.
  task automatic step(input logic e, input logic [SIZE-1:0] it, input logic [BD-1:0] td,
                      input logic [NP-1:0] bz);
    int   d;
    logic valid;
    logic blocked;
    logic exp_read;
    bus.empty = e; bus.item_in = it; bus.table_data = td; bus.port_busy = bz;
    #2;
    d        = (m_pos == 0) ? int'(td) : m_route;
    valid    = (d < NP);
    blocked  = valid && bz[d];
    exp_read = !e && !blocked;
    chk("read", 32'(bus.read), 32'(exp_read));
    chk("table_addr", 32'(bus.table_addr), 32'(it));
    @(posedge clk);
    if (exp_read) begin
      if (valid) begin
        m_item = it;
        m_ena  = NP'(1 << d);
      end else begin
        m_ena = '0;
      end
      if (m_pos == 0) begin
        m_route = int'(td);
        if (!valid) m_err = 1'b1;
      end
      m_pos  = (m_pos + 1) % PL;
      m_scnt = 0;
    end else begin
      m_ena = '0;
      if (!e && blocked && m_scnt < SM) m_scnt++;
    end
    m_stall = (m_scnt == SM);
    #1;
    chk_regs("cyc");
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset;
    bus.empty = 1'b0; bus.item_in = 8'h5A; bus.table_data = 3'd1; bus.port_busy = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_read", 32'(bus.read), 32'd0);
    chk_regs("rst");
    @(posedge clk);
    #1;
    chk("rst_hold_read", 32'(bus.read), 32'd0);
    chk_regs("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic align_head;
    for (int k = 0; k < PL && m_pos != 0; k++) begin
      step(1'b0, 8'($urandom), 3'($urandom_range(0, NP - 1)), '0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.empty = 1'b1; bus.item_in = '0; bus.table_data = '0; bus.port_busy = '0;
    model_reset();
    #3;
    do_reset();

    // Route locked on head: body items ignore table_data; next head uses it again.
    step(1'b0, 8'h11, 3'd1, 5'b00000);
    step(1'b0, 8'h12, 3'd3, 5'b00000);
    step(1'b0, 8'h13, 3'd3, 5'b11101);
    step(1'b0, 8'h14, 3'd3, 5'b00000);
    step(1'b0, 8'h22, 3'd4, 5'b00000);
    step(1'b0, 8'h23, 3'd0, 5'b01111);
    step(1'b0, 8'h24, 3'd0, 5'b00000);
    step(1'b0, 8'h25, 3'd0, 5'b00000);

    // Target busy 3 cycles mid-packet, then resumes with the same item.
    step(1'b0, 8'h40, 3'd0, 5'b00000);
    step(1'b0, 8'h41, 3'd2, 5'b00000);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h42, 3'd2, 5'b00001);
    step(1'b0, 8'h42, 3'd2, 5'b11110);
    step(1'b0, 8'h43, 3'd2, 5'b00000);

    // Empty in the middle of a packet holds everything.
    step(1'b0, 8'h50, 3'd2, 5'b00000);
    step(1'b1, 8'h51, 3'd0, 5'b00100);
    step(1'b1, 8'h51, 3'd0, 5'b00000);
    step(1'b0, 8'h51, 3'd0, 5'b00000);
    step(1'b0, 8'h52, 3'd0, 5'b00000);
    step(1'b0, 8'h53, 3'd0, 5'b00000);

    // Target busy 6 cycles: stall saturates and drops after the transfer.
    step(1'b0, 8'h60, 3'd3, 5'b00000);
    for (int k = 0; k < 6; k++) step(1'b0, 8'h61, 3'd0, 5'b01000);
    step(1'b0, 8'h61, 3'd0, 5'b00000);
    step(1'b0, 8'h62, 3'd0, 5'b00000);
    step(1'b0, 8'h63, 3'd0, 5'b00000);

    // Random traffic with in-range directions.
    for (int k = 0; k < 250; k++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 3'($urandom_range(0, NP - 1)),
           ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0);
    end

    // Out-of-range head: whole packet discarded, error sticks.
    align_head();
    step(1'b0, 8'h70, 3'd6, 5'b00000);
    step(1'b0, 8'h71, 3'd1, 5'b00000);
    step(1'b0, 8'h72, 3'd1, 5'b00010);
    step(1'b1, 8'h73, 3'd1, 5'b00000);
    step(1'b0, 8'h73, 3'd1, 5'b00000);
    step(1'b0, 8'h74, 3'd1, 5'b00000);
    step(1'b0, 8'h75, 3'd5, 5'b00000);

    // Random traffic including out-of-range directions.
    for (int k = 0; k < 250; k++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 3'($urandom),
           ($urandom_range(0, 2) == 0) ? NP'($urandom) : '0);
    end

    // Reset after 2 of 4 items: lock abandoned, next item is a head.
    do_reset();
    step(1'b0, 8'h80, 3'd3, 5'b00000);
    step(1'b0, 8'h81, 3'd0, 5'b00000);
    do_reset();
    step(1'b0, 8'h82, 3'd2, 5'b00000);
    step(1'b0, 8'h83, 3'd4, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
